// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//
// Shared definitions for the bit-serial adder:
//   - DEFAULT_WIDTH : default operand/sum width in bits
//   - state_t       : 2-bit FSM state type
//   - IDLE/RUN/DONE : state encodings (0/1/2)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Existing 1-bit full adder cell, used unmodified by serial_adder.
//
// Ports:
//   A, B  in  operand bits
//   Cin   in  carry in
//   S     out sum bit
//   Cout  out carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder built around a single full_adder cell. Operands
// are latched on an accepted start, then one bit per clock is added LSB-first
// with the carry held in a flip-flop. The result is registered into sum/cout
// on the last bit and announced by a one-cycle done pulse.
//
// Optional build macro: SERIAL_ADDER_OVF_EN
//   defined   : ovf = two's-complement overflow of the last addition
//   undefined : ovf tied to 0, no extra flip-flop
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled in IDLE or DONE only
//   a, b   in   WIDTH-bit operands, latched on accepted start
//   cin    in   carry-in, latched on accepted start
//   busy   out  high while bits are being added (RUN)
//   done   out  one-cycle pulse, results valid from this cycle
//   sum    out  WIDTH-bit registered result
//   cout   out  registered carry-out
//   ovf    out  registered signed overflow (0 unless SERIAL_ADDER_OVF_EN)
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc_sr;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_cout;
    logic             last_edge;

    full_adder u_full_adder (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cin  (carry),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // The new sum bit enters at the MSB; after WIDTH shifts the first bit
    // computed has reached bit 0. Written as shift-then-OR so every bit of
    // acc_sr is consumed.
    assign acc_next  = (acc_sr >> 1) | {fa_s, {(WIDTH-1){1'b0}}};
    assign last_edge = (state == RUN) && (cnt == LAST_BIT);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            acc_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        acc_sr <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc_sr <= acc_next;
                    carry  <= fa_cout;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        sum   <= acc_next;
                        cout  <= fa_cout;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the final edge the carry flop holds the carry into the MSB;
    // overflow is that carry disagreeing with the carry out of the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (last_edge) begin
            ovf <= carry ^ fa_cout;
        end
    end
`else
    assign ovf = 1'b0;

    // last_edge only drives the overflow flop; keep it referenced here.
    logic unused_last_edge;
    assign unused_last_edge = last_edge;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed testbench for serial_adder (WIDTH=8): a table of hand-computed
// vectors, hand-written sequences for start-while-busy, back-to-back start and
// asynchronous reset mid-operation, and a pseudo-random sweep checked against
// a behavioural a+b+cin model.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;

`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;   // value when overflow detection is built
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Counts cycles (sampled on falling edges) until done, starting from the
    // first cycle after the start edge. Bounded so a dead DUT cannot hang.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && lat <= 3 * WIDTH) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic apply(input string name, input logic [WIDTH-1:0] va,
                         input logic [WIDTH-1:0] vb, input logic vc,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int lat;
        int bc;
        logic [WIDTH-1:0] held;
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check({name, " latency"}, lat, WIDTH + 1);
        check({name, " busy cycles"}, bc, WIDTH);
        check({name, " busy in done"}, busy, 1'b0);
        check({name, " sum"}, sum, es);
        check({name, " cout"}, cout, ec);
        check({name, " ovf"}, ovf, eo & OVF_ON);
        held = sum;
        @(negedge clk);
        check({name, " done one cycle"}, done, 1'b0);
        check({name, " sum held"}, sum, held);
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        int bc;
        int n_done;
        logic [WIDTH:0] full;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic rc;
        logic eo;

        vecs[0]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8]  = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        vecs[9]  = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[10] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[11] = '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset sum",  sum,  '0);
        check("reset cout", cout, 1'b0);
        check("reset ovf",  ovf,  1'b0);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        // start held high through RUN while operands wiggle: one done, result
        // from the operands latched at the start edge.
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        n_done = 0;
        for (int i = 1; i <= WIDTH; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            if (i == WIDTH) start = 1'b0;
        end
        check("held start early done", n_done, 0);
        @(negedge clk);
        check("held start done", done, 1'b1);
        check("held start sum", sum, 8'h10);
        check("held start cout", cout, 1'b0);
        n_done = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("held start extra done", n_done, 0);

        // Back-to-back: new start accepted in the DONE cycle.
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check("b2b first latency", lat, WIDTH + 1);
        check("b2b first sum", sum, 8'h10);
        a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy after restart", busy, 1'b1);
        wait_done(lat, bc);
        check("b2b second latency", lat, WIDTH + 1);
        check("b2b second sum", sum, 8'h07);
        check("b2b second cout", cout, 1'b0);

        // Asynchronous reset in RUN cycle 4 of 0F+01; sum currently 07.
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async reset sum", sum, '0);
        check("async reset cout", cout, 1'b0);
        check("async reset busy", busy, 1'b0);
        check("async reset done", done, 1'b0);
        check("async reset ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        check("post-reset idle", n_done, 0);
        apply("post-reset op", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

        // Pseudo-random sweep against a behavioural model.
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            eo = (ra[WIDTH-1] == rb[WIDTH-1]) && (full[WIDTH-1] != ra[WIDTH-1]);
            apply($sformatf("rand %0h+%0h+%0b", ra, rb, rc), ra, rb, rc,
                  full[WIDTH-1:0], full[WIDTH], eo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
